// File: rtl/rv32_shift_pkg.sv
// rv32_shift_pkg
// Shared definitions for the RV32I multi-cycle shift unit.
//   XLEN         : datapath width
//   shift_op_e   : op field encodings (SLL / SRL / SRA / reserved)
//   shift_state_e: control FSM states
package rv32_shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    SHIFT_SLL  = 2'b00,
    SHIFT_SRL  = 2'b01,
    SHIFT_RSVD = 2'b10,
    SHIFT_SRA  = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } shift_state_e;

endpackage

// File: rtl/rv32_shift_step.sv
// rv32_shift_step
// Combinational single-step shifter: shifts a value by 0..STEP positions.
// Ports:
//   value   in  XLEN  value to shift
//   amount  in  AW    positions to shift this step (0..STEP)
//   op      in  2     SLL / SRL / SRA / reserved (reserved passes through)
//   fill    in  1     bit shifted in from the MSB side for SRA
//   shifted out XLEN  shifted value
module rv32_shift_step
  import rv32_shift_pkg::*;
#(
  parameter int STEP = 1,
  localparam int AW = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] value,
  input  logic [AW-1:0]   amount,
  input  logic [1:0]      op,
  input  logic            fill,
  output logic [XLEN-1:0] shifted
);

  logic [XLEN-1:0] fill_mask;

  always_comb begin
    // Ones in the top 'amount' bit positions; ORed into a logical right
    // shift this yields the arithmetic right shift.
    fill_mask = fill ? ~({XLEN{1'b1}} >> amount) : '0;
    case (op)
      SHIFT_SLL: shifted = value << amount;
      SHIFT_SRL: shifted = value >> amount;
      SHIFT_SRA: shifted = (value >> amount) | fill_mask;
      default:   shifted = value;
    endcase
  end

endmodule

// File: rtl/rv32_shift_unit.sv
// rv32_shift_unit
// Multi-cycle SLL/SRL/SRA execution unit. The working register is shifted
// by up to STEP positions per BUSY cycle until the remaining count is zero.
//
// state | meaning
// IDLE  | waiting for an operand bundle, in_ready=1
// BUSY  | shifting, min(STEP, remaining) positions per cycle
// DONE  | result presented with out_valid=1 until out_ready
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid / in_ready  operand bundle handshake (operand, shamt, op)
//   flush                synchronous abort, forces IDLE
//   out_valid / out_ready result handshake
//   result               working register contents
module rv32_shift_unit
  import rv32_shift_pkg::*;
#(
  parameter int STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     operand,
  input  logic [4:0]      shamt,
  input  logic [1:0]      op,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     result
);

  localparam int              AW       = $clog2(STEP + 1);
  localparam logic [4:0]      STEP_CNT = 5'(STEP);
  localparam logic [AW-1:0]   STEP_AMT = AW'(STEP);

  shift_state_e    state_q, state_d;
  logic [XLEN-1:0] work_q, work_d;
  logic [4:0]      rem_q, rem_d;
  shift_op_e       op_q, op_d;
  logic            fill_q, fill_d;
  logic [AW-1:0]   step_amt;
  logic [XLEN-1:0] step_out;
  logic            accept;

  // in_ready is qualified by rst_n so it reads low while reset is held.
  assign in_ready  = (state_q == IDLE) && rst_n;
  assign accept    = in_valid && in_ready && !flush;
  assign out_valid = (state_q == DONE);
  assign result    = work_q;

  // k = min(STEP, remaining); rem_q < STEP fits in AW bits.
  assign step_amt = (rem_q < STEP_CNT) ? rem_q[AW-1:0] : STEP_AMT;

  rv32_shift_step #(
    .STEP(STEP)
  ) u_step (
    .value  (work_q),
    .amount (step_amt),
    .op     (op_q),
    .fill   (fill_q),
    .shifted(step_out)
  );

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          work_d = operand;
          rem_d  = shamt;
          op_d   = shift_op_e'(op);
          // SRA fills with the sign of the operand as latched.
          fill_d = operand[XLEN-1];
          if ((shamt == '0) || (op == SHIFT_RSVD)) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        work_d = step_out;
        rem_d  = rem_q - 5'(step_amt);
        if (rem_q <= STEP_CNT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // flush wins over everything, including a simultaneous out_ready.
    if (flush) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_q <= '0;
      rem_q  <= '0;
      op_q   <= SHIFT_SLL;
      fill_q <= 1'b0;
    end else begin
      work_q <= work_d;
      rem_q  <= rem_d;
      op_q   <= op_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: tb/tb_rv32_shift_unit.sv
module tb_rv32_shift_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid  [2];
  logic [31:0] operand   [2];
  logic [4:0]  shamt     [2];
  logic [1:0]  op        [2];
  logic        flush     [2];
  logic        out_ready [2];
  logic        in_ready  [2];
  logic        out_valid [2];
  logic [31:0] result    [2];

  int checks   = 0;
  int failures = 0;

  // Instance 0 uses STEP=1, instance 1 uses STEP=4.
  rv32_shift_unit #(.STEP(1)) u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .operand(operand[0]), .shamt(shamt[0]), .op(op[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .result(result[0]));

  rv32_shift_unit #(.STEP(4)) u_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .operand(operand[1]), .shamt(shamt[1]), .op(op[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .result(result[1]));

  function automatic int step_of(int g);
    return (g == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] ref_shift(logic [1:0] o, logic [31:0] v, logic [4:0] s);
    case (o)
      2'b00:   return v << s;
      2'b01:   return v >> s;
      2'b11:   return $signed(v) >>> s;
      default: return v;
    endcase
  endfunction

  // Cycles from the accept edge to the first cycle with out_valid=1.
  function automatic int ref_lat(logic [1:0] o, int s, int step);
    if (s == 0 || o == 2'b10) return 1;
    return (s + step - 1) / step + 1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: protocol phase per instance (0 idle, 1 shifting,
  // 2 holding result), cycles still to wait, and the expected result.
  int          m_phase [2] = '{0, 0};
  int          m_wait  [2] = '{0, 0};
  logic [31:0] m_res   [2] = '{32'h0, 32'h0};

  for (genvar g = 0; g < 2; g++) begin : g_mon
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_phase[g] <= 0;
        m_wait[g]  <= 0;
        m_res[g]   <= 32'h0;
      end else if (flush[g]) begin
        m_phase[g] <= 0;
      end else begin
        case (m_phase[g])
          0: if (in_valid[g]) begin
            m_res[g]   <= ref_shift(op[g], operand[g], shamt[g]);
            m_wait[g]  <= ref_lat(op[g], int'(shamt[g]), step_of(g)) - 1;
            m_phase[g] <= (ref_lat(op[g], int'(shamt[g]), step_of(g)) == 1) ? 2 : 1;
          end
          1: begin
            m_wait[g] <= m_wait[g] - 1;
            if (m_wait[g] == 1) m_phase[g] <= 2;
          end
          default: if (out_ready[g]) m_phase[g] <= 0;
        endcase
      end
    end

    always @(negedge clk) begin
      chk($sformatf("u%0d in_ready", g), {31'b0, in_ready[g]},
          {31'b0, (m_phase[g] == 0) && (rst_n == 1'b1)});
      chk($sformatf("u%0d out_valid", g), {31'b0, out_valid[g]},
          {31'b0, m_phase[g] == 2});
      if (m_phase[g] == 2)
        chk($sformatf("u%0d result", g), result[g], m_res[g]);
      if (!rst_n)
        chk($sformatf("u%0d reset_result", g), result[g], 32'h0);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic offer(int g, logic [1:0] o, logic [31:0] v, logic [4:0] s);
    in_valid[g] = 1'b1;
    op[g]       = o;
    operand[g]  = v;
    shamt[g]    = s;
  endtask

  // Call just after the accept edge; counts cycles until out_valid.
  task automatic wait_valid(int g, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid[g] && lat < 200);
    if (!out_valid[g]) begin
      checks++;
      failures++;
      $display("FAIL u%0d wait_valid: out_valid never rose within %0d cycles", g, lat);
    end
  endtask

  task automatic consume(int g);
    tick();
    out_ready[g] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[g] = 1'b0;
  endtask

  task automatic run_op(int g, logic [1:0] o, logic [31:0] v, logic [4:0] s,
                        logic [31:0] exp_res, int exp_lat, string name);
    int lat;
    tick();
    offer(g, o, v, s);
    chk({name, " ready_before"}, {31'b0, in_ready[g]}, 32'h1);
    @(posedge clk);
    #1;
    in_valid[g] = 1'b0;
    operand[g]  = 32'hDEAD_BEEF;
    shamt[g]    = 5'd17;
    wait_valid(g, lat);
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " result"}, result[g], exp_res);
    chk({name, " ready_in_done"}, {31'b0, in_ready[g]}, 32'h0);
    consume(g);
  endtask

  initial begin
    int          lat, g, s;
    logic [1:0]  o;
    logic [31:0] v;

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid[i] = 1'b0; operand[i] = '0; shamt[i] = '0; op[i] = '0;
      flush[i] = 1'b0; out_ready[i] = 1'b0;
    end

    // Pin the reference model with hand-computed values.
    chk("model_sra", ref_shift(2'b11, 32'h8000_0000, 5'd4), 32'hF800_0000);
    chk("model_srl", ref_shift(2'b01, 32'hFFFF_0000, 5'd8), 32'h00FF_FF00);
    chk("model_lat", ref_lat(2'b11, 5, 4), 3);

    tick();
    chk("reset_in_ready", {31'b0, in_ready[0]}, 32'h0);
    chk("reset_out_valid", {31'b0, out_valid[1]}, 32'h0);
    chk("reset_result", result[0], 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_in_ready", {31'b0, in_ready[0]}, 32'h1);

    run_op(0, 2'b11, 32'h8000_0000, 5'd4,  32'hF800_0000, 5,  "sra4");
    run_op(0, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 32, "sll31");
    run_op(0, 2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001, 32, "srl31");
    run_op(0, 2'b00, 32'h1234_5678, 5'd0,  32'h1234_5678, 1,  "shamt0");
    run_op(0, 2'b10, 32'h1234_5678, 5'd9,  32'h1234_5678, 1,  "rsvd");
    run_op(1, 2'b11, 32'hF000_000F, 5'd5,  32'hFF80_0000, 3,  "step4_sra5");
    run_op(1, 2'b00, 32'h0000_0001, 5'd31, 32'h8000_0000, 9,  "step4_sll31");

    // Backpressure with a second bundle waiting.
    tick();
    offer(0, 2'b01, 32'hFFFF_0000, 5'd8);
    @(posedge clk);
    #1;
    offer(0, 2'b00, 32'h0000_0001, 5'd3);
    wait_valid(0, lat);
    chk("bp latency", lat, 9);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp hold_result", result[0], 32'h00FF_FF00);
      chk("bp hold_ready", {31'b0, in_ready[0]}, 32'h0);
    end
    consume(0);
    @(negedge clk);
    chk("bp ready_after", {31'b0, in_ready[0]}, 32'h1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    wait_valid(0, lat);
    chk("bp2 latency", lat, 4);
    chk("bp2 result", result[0], 32'h0000_0008);
    consume(0);

    // Flush in the third BUSY cycle of a shamt=10 op.
    tick();
    offer(0, 2'b00, 32'h0000_0003, 5'd10);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    tick();
    tick();
    tick();
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    flush[0] = 1'b0;
    @(negedge clk);
    chk("flush ready", {31'b0, in_ready[0]}, 32'h1);
    chk("flush valid", {31'b0, out_valid[0]}, 32'h0);

    // Bundle offered together with flush must not be taken.
    tick();
    offer(0, 2'b00, 32'h0000_0003, 5'd2);
    flush[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    flush[0]    = 1'b0;
    @(negedge clk);
    chk("flush_accept ready", {31'b0, in_ready[0]}, 32'h1);

    // Reset pulse mid-BUSY.
    tick();
    offer(1, 2'b01, 32'hABCD_0000, 5'd20);
    @(posedge clk);
    #1;
    in_valid[1] = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    chk("rst_mid result", result[1], 32'h0);
    chk("rst_mid valid", {31'b0, out_valid[1]}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid ready", {31'b0, in_ready[1]}, 32'h1);
    run_op(1, 2'b01, 32'hABCD_0000, 5'd20, 32'h0000_0ABC, 6, "after_rst");
    run_op(0, 2'b00, 32'h0000_0003, 5'd10, 32'h0000_0C00, 11, "after_flush");

    // Randomized operations, occasional flush and backpressure.
    for (int n = 0; n < 300; n++) begin
      g = int'($urandom_range(0, 1));
      o = 2'($urandom);
      v = $urandom;
      s = int'($urandom_range(0, 31));
      tick();
      offer(g, o, v, 5'(s));
      @(posedge clk);
      #1;
      in_valid[g] = 1'b0;
      operand[g]  = $urandom;
      shamt[g]    = 5'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 4)) tick();
        tick();
        flush[g]     = 1'b1;
        out_ready[g] = 1'($urandom);
        @(posedge clk);
        #1;
        flush[g]     = 1'b0;
        out_ready[g] = 1'b0;
      end else begin
        wait_valid(g, lat);
        chk($sformatf("rand u%0d latency", g), lat, ref_lat(o, s, step_of(g)));
        chk($sformatf("rand u%0d result", g), result[g], ref_shift(o, v, 5'(s)));
        repeat ($urandom_range(0, 3)) tick();
        consume(g);
      end
    end

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv32_shift_unit.md
# rv32_shift_unit

Multi-cycle shift execution unit for the RV32I datapath, implementing SLL/SRL/SRA (and their immediate forms) by iterative shifting. It complements the fixed left-by-one immediate shifter used for branch/jump offset generation. Here the shift amount is variable, right shifts are supported, and the operation runs over several cycles. It sits beside the ALU in the execute stage and exchanges operands and results with the pipeline control over valid/ready handshakes.

## Interface
- STEP, default 1: bit positions shifted per BUSY cycle; legal values 1, 2, 4, 8.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  unit can accept a bundle; high only in IDLE.
- operand  input  32  value to shift (rs1).
- shamt  input  5  shift amount (rs2[4:0] or imm[4:0]).
- op  input  2  2'b00 SLL, 2'b01 SRL, 2'b11 SRA, 2'b10 reserved.
- flush  input  1  synchronous abort of any in-flight operation.
- out_valid  output  1  result valid; held until accepted.
- out_ready  input  1  consumer accepts result.
- result  output  32  shifted value.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, latch operand into the working register, shamt into the remaining counter, and op.
  - If shamt==0 or op==2'b10, go to DONE with the working register unchanged.
  - Otherwise go to BUSY.
- BUSY: each cycle, shift the working register by k=min(STEP, remaining) and set remaining -= k.
  - SLL: zero fill from the LSB.
  - SRL: zero fill from the MSB.
  - SRA: fill from the MSB with the sign bit of the latched operand.
  - When remaining becomes 0, go to DONE.
- DONE: out_valid=1 and result=working register. On out_ready, go to IDLE. A new bundle cannot be accepted in the same cycle.
- flush: overrides every state. Next state is IDLE and out_valid drops the next cycle. A bundle offered in the same cycle as flush is not accepted.
- Reserved op 2'b10 passes the operand through unchanged with no error signalling.
- Arithmetic: the full 32-bit result is determined by shamt mod 32. No width extension is performed.

## Timing
- Reset values: in_ready=0 while rst_n low, 1 in the first cycle after release (IDLE). out_valid=0, result=32'h0, state=IDLE, counter=0.
- Latency from the accept edge to the first cycle out_valid=1 is ceil(shamt/STEP)+1 cycles. For shamt==0 this is 1 cycle.
- Throughput: one operation per ceil(shamt/STEP)+2 cycles when out_ready is held high.
- result is stable while out_valid=1 and out_ready=0. The unit holds the result indefinitely.
- in_ready=0 in BUSY and DONE. Operand input changes in those states are ignored.
- Reset asserted mid-BUSY or in DONE returns all outputs to their reset values immediately. There is no partial result.
- flush and out_ready asserted together in DONE behave as a plain flush. The result counts as not consumed, and the consumer must ignore it.

## Structure
- Shared package rv32_shift_pkg contains:
  - op encodings: SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_RSVD.
  - state enum: IDLE, BUSY, DONE.
  - constant XLEN=32.
- One sub-module: rv32_shift_step, a combinational shift of a 32-bit value by a 0..STEP amount. Inputs are the value, the amount, op, and the fill bit. The top level owns the FSM, the counter and the handshake.

## Test plan
- SRA, operand=32'h8000_0000, shamt=4, STEP=1 -> result 32'hF800_0000; out_valid 5 cycles after accept.
- SLL, operand=32'h0000_0001, shamt=31, STEP=1 -> result 32'h8000_0000 after 32 cycles. Also SRL of 32'h8000_0000 by 31 -> 32'h0000_0001.
- shamt=0 and op=2'b10 with operand=32'h1234_5678 -> result 32'h1234_5678; out_valid 1 cycle after accept; in_ready low during that cycle.
- Backpressure: SRL 32'hFFFF_0000 by 8 -> 32'h00FF_FF00. Hold out_ready=0 for 3 cycles: result stable, in_ready=0, second bundle not accepted until the cycle after out_ready.
- STEP=4, SRA 32'hF000_000F by 5 -> 32'hFF80_0000; exactly 2 BUSY cycles, out_valid 3 cycles after accept.
- Flush in the 3rd BUSY cycle of a shamt=10 op, then separately rst_n pulse mid-BUSY -> back to IDLE, no out_valid pulse, in_ready=1 next cycle. A follow-up op completes correctly.
